// File: rtl/coef_pkg.sv
// Shared types and elaboration-time maths for the cos/sin coefficient sequencer.
// Nothing here turns into run-time arithmetic; coef_val is only called with constant arguments.
package coef_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int MODE_COS  = 0;
  localparam int MODE_SIN  = 1;
  localparam int MAX_TERMS = 8;

  function automatic logic [63:0] fact(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 2; i <= n; i++) r = r * 64'(i);
    return r;
  endfunction

  // Round-half-up of 2^frac / (2k+mode)!, computed as floor((2^(frac+1) + f) / 2f).
  function automatic logic [63:0] coef_val(input int k, input int mode, input int width,
                                           input int frac);
    logic [63:0] f;
    logic [63:0] q;
    logic [63:0] maxv;
    f    = fact(2 * k + mode);
    q    = ((64'd1 << (frac + 1)) + f) / (f << 1);
    maxv = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (q > maxv) ? maxv : q;
  endfunction

endpackage

// File: rtl/coef_seq_if.sv
// Coefficient stream bundle between the sequencer and the multiply-accumulate stage.
interface coef_seq_if #(
  parameter int WIDTH = 16
);
  logic             coef_valid;
  logic             coef_ready;
  logic [WIDTH-1:0] coef;
  logic             coef_neg;
  logic [2:0]       coef_idx;
  logic             coef_last;

  modport master (output coef_valid, coef, coef_neg, coef_idx, coef_last, input coef_ready);
  modport slave  (input coef_valid, coef, coef_neg, coef_idx, coef_last, output coef_ready);
endinterface

// File: rtl/coef_table.sv
// Combinational (mode, k) -> magnitude lookup; entries are constants fixed at elaboration.
module coef_table
  import coef_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int TERMS = 7
) (
  input  logic             mode,
  input  logic [2:0]       k,
  output logic [WIDTH-1:0] mag
);

  logic [WIDTH-1:0] cos_tab [MAX_TERMS];
  logic [WIDTH-1:0] sin_tab [MAX_TERMS];

  for (genvar g = 0; g < MAX_TERMS; g++) begin : g_tab
    localparam logic [63:0] COS_V = (g < TERMS) ? coef_val(g, MODE_COS, WIDTH, FRAC) : 64'd0;
    localparam logic [63:0] SIN_V = (g < TERMS) ? coef_val(g, MODE_SIN, WIDTH, FRAC) : 64'd0;
    assign cos_tab[g] = COS_V[WIDTH-1:0];
    assign sin_tab[g] = SIN_V[WIDTH-1:0];
  end

  assign mag = mode ? sin_tab[k] : cos_tab[k];

endmodule

// File: rtl/coef_seq.sv
// Streams the first N Taylor coefficients of cos or sin over a valid/ready port.
// Output register is reloaded from the table on each handshake, so a ready sink gets one term per cycle.
module coef_seq
  import coef_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int TERMS = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [3:0]  n_terms,
  coef_seq_if.master  cif,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] TERMS_L = 4'(TERMS);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [3:0]       n_q, n_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] coef_q, coef_d;
  logic             neg_q, neg_d;
  logic [2:0]       idx_q, idx_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  logic             tbl_mode;
  logic [2:0]       tbl_k;
  logic [WIDTH-1:0] tbl_mag;
  logic [3:0]       n_clamp;
  logic             hs;

  coef_table #(.WIDTH(WIDTH), .FRAC(FRAC), .TERMS(TERMS)) u_table (
    .mode (tbl_mode),
    .k    (tbl_k),
    .mag  (tbl_mag)
  );

  assign n_clamp = (n_terms == 4'd0 || n_terms > TERMS_L) ? TERMS_L : n_terms;
  assign hs      = valid_q && cif.coef_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 1'b0;
      n_q     <= 4'd0;
      valid_q <= 1'b0;
      coef_q  <= '0;
      neg_q   <= 1'b0;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      coef_q  <= coef_d;
      neg_q   <= neg_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    n_d      = n_q;
    valid_d  = valid_q;
    coef_d   = coef_q;
    neg_d    = neg_q;
    idx_d    = idx_q;
    last_d   = last_q;
    done_d   = 1'b0;
    tbl_mode = mode_q;
    tbl_k    = idx_q + 3'd1;

    case (state_q)
      IDLE: begin
        // Look up term 0 with the live mode so it can be loaded on the start edge.
        tbl_mode = mode;
        tbl_k    = 3'd0;
        if (start) begin
          mode_d  = mode;
          n_d     = n_clamp;
          valid_d = 1'b1;
          coef_d  = tbl_mag;
          neg_d   = 1'b0;
          idx_d   = 3'd0;
          last_d  = (n_clamp == 4'd1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (hs) begin
          if (!last_q) begin
            idx_d  = tbl_k;
            coef_d = tbl_mag;
            neg_d  = tbl_k[0];
            last_d = ({1'b0, tbl_k} == n_q - 4'd1);
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cif.coef_valid = valid_q;
  assign cif.coef       = coef_q;
  assign cif.coef_neg   = neg_q;
  assign cif.coef_idx   = idx_q;
  assign cif.coef_last  = last_q;
  assign busy           = (state_q == STREAM);
  assign done           = done_q;

endmodule

// File: tb/tb_coef_seq.sv
// Scoreboard bench for coef_seq at WIDTH=16, FRAC=8, TERMS=7.
module tb_coef_seq;

  typedef struct {
    logic [15:0] c;
    logic        neg;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] n_terms = 4'd0;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  exp_t sb[$];
  exp_t e;
  logic mdl_busy = 1'b0;
  logic mdl_done = 1'b0;
  logic nxt_done;
  logic prev_stall = 1'b0;
  logic [15:0] h_coef;
  logic        h_neg;
  logic [2:0]  h_idx;
  logic        h_last;

  coef_seq_if #(.WIDTH(16)) cif ();

  coef_seq #(.WIDTH(16), .FRAC(8), .TERMS(7)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .n_terms (n_terms),
    .cif     (cif),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] gold(input logic m, input int k);
    if (!m) begin
      case (k)
        0: return 16'd256;
        1: return 16'd128;
        2: return 16'd11;
        default: return 16'd0;
      endcase
    end else begin
      case (k)
        0: return 16'd256;
        1: return 16'd43;
        2: return 16'd2;
        default: return 16'd0;
      endcase
    end
  endfunction

  // Monitor and reference model: sample at negedge, then account for the inputs seen at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(cif.coef_valid), 0);
      chk("rst_coef", 32'(cif.coef), 0);
      chk("rst_misc", {28'd0, cif.coef_neg, cif.coef_last, busy, done}, 0);
      chk("rst_idx", 32'(cif.coef_idx), 0);
      sb.delete();
      mdl_busy   = 1'b0;
      mdl_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("valid", 32'(cif.coef_valid), 32'(mdl_busy));
      chk("busy", 32'(busy), 32'(mdl_busy));
      chk("done", 32'(done), 32'(mdl_done));
      if (prev_stall) begin
        chk("hold_coef", 32'(cif.coef), 32'(h_coef));
        chk("hold_neg", 32'(cif.coef_neg), 32'(h_neg));
        chk("hold_idx", 32'(cif.coef_idx), 32'(h_idx));
        chk("hold_last", 32'(cif.coef_last), 32'(h_last));
      end
      nxt_done = 1'b0;
      if (cif.coef_valid && cif.coef_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("coef", 32'(cif.coef), 32'(e.c));
          chk("neg", 32'(cif.coef_neg), 32'(e.neg));
          chk("idx", 32'(cif.coef_idx), 32'(e.idx));
          chk("last", 32'(cif.coef_last), 32'(e.last));
          if (e.last) begin
            mdl_busy = 1'b0;
            nxt_done = 1'b1;
          end
        end
      end else if (!mdl_busy && start) begin
        automatic int n = (n_terms == 0 || n_terms > 7) ? 7 : int'(n_terms);
        for (int k = 0; k < n; k++) begin
          e.c    = gold(mode, k);
          e.neg  = k[0];
          e.idx  = 3'(k);
          e.last = (k == n - 1);
          sb.push_back(e);
        end
        mdl_busy = 1'b1;
      end
      mdl_done   = nxt_done;
      prev_stall = cif.coef_valid && !cif.coef_ready;
      h_coef     = cif.coef;
      h_neg      = cif.coef_neg;
      h_idx      = cif.coef_idx;
      h_last     = cif.coef_last;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input logic m, input logic [3:0] n);
    start   = 1'b1;
    mode    = m;
    n_terms = n;
    cyc();
    start   = 1'b0;
    mode    = ~m;
    n_terms = 4'($urandom_range(0, 15));
  endtask

  // rdy_sel: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  task automatic drain(input int rdy_sel, input logic poke_start);
    int i;
    for (i = 0; i < 200 && busy; i++) begin
      case (rdy_sel)
        0: cif.coef_ready = 1'b1;
        1: cif.coef_ready = (i % 3 == 0);
        default: cif.coef_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke_start) begin
        start   = 1'($urandom_range(0, 1));
        mode    = 1'($urandom_range(0, 1));
        n_terms = 4'($urandom_range(0, 15));
      end
      cyc();
    end
    start = 1'b0;
    cif.coef_ready = 1'b1;
    if (busy) chk("timeout", 1, 0);
  endtask

  initial begin
    int hs0;
    cif.coef_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_busy_drv", 32'(busy), 0);
    rst_n = 1'b1;
    cyc();

    // cosine, 4 terms, always ready
    start_stream(1'b0, 4'd4);
    drain(0, 1'b0);
    cyc();

    // sine, 3 terms, stalled
    hs0 = hs_cnt;
    start_stream(1'b1, 4'd3);
    drain(1, 1'b0);
    chk("sin_hs", 32'(hs_cnt - hs0), 3);
    cyc();

    // clamping of out-of-range counts
    hs0 = hs_cnt;
    start_stream(1'b0, 4'd0);
    drain(2, 1'b0);
    chk("n0_hs", 32'(hs_cnt - hs0), 7);
    cyc();
    hs0 = hs_cnt;
    start_stream(1'b1, 4'd9);
    drain(2, 1'b0);
    chk("n9_hs", 32'(hs_cnt - hs0), 7);
    cyc();

    // starts while busy are ignored; a start in the done cycle launches the next stream
    start_stream(1'b0, 4'd5);
    drain(2, 1'b1);
    chk("b2b_done", 32'(done), 1);
    start   = 1'b1;
    mode    = 1'b1;
    n_terms = 4'd2;
    cif.coef_ready = 1'b0;
    cyc();
    start = 1'b0;
    chk("b2b_valid", 32'(cif.coef_valid), 1);
    chk("b2b_idx", 32'(cif.coef_idx), 0);
    chk("b2b_coef", 32'(cif.coef), 256);
    drain(0, 1'b0);
    cyc();

    // asynchronous reset mid-stream at k=2 under backpressure
    start_stream(1'b0, 4'd7);
    for (int i = 0; i < 20 && cif.coef_idx != 3'd2; i++) cyc();
    cif.coef_ready = 1'b0;
    chk("rst_at_k2", 32'(cif.coef_idx), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(cif.coef_valid), 0);
    chk("arst_coef", 32'(cif.coef), 0);
    chk("arst_idx", 32'(cif.coef_idx), 0);
    chk("arst_busy", 32'(busy), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cif.coef_ready = 1'b1;
    repeat (3) cyc();
    start_stream(1'b1, 4'd5);
    drain(0, 1'b0);
    cyc();

    // single-term stream
    cif.coef_ready = 1'b0;
    start_stream(1'b0, 4'd1);
    chk("n1_last", 32'(cif.coef_last), 1);
    chk("n1_coef", 32'(cif.coef), 256);
    cyc();
    drain(0, 1'b0);
    repeat (3) cyc();

    chk("sb_left", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
